// File: rtl/cksum_update.sv
// Checksum-rewrite stage: zeroes a header's 16-bit checksum field, hands the header
// to an external checksum unit, then writes the returned value back big-endian.
module cksum_update #(
   parameter int unsigned HDR_MAX_LEN = 64,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_i,
   input  logic [ADDR_W-1:0]            field_start_i,
   input  logic [ADDR_W-1:0]            field_len_i,
   input  logic [ADDR_W-1:0]            cksum_off_i,
   output logic                         cksum_start_o,
   output logic [HDR_MAX_LEN-1:0][7:0]  cksum_hdr_o,
   output logic [ADDR_W-1:0]            cksum_field_start_o,
   output logic [ADDR_W-1:0]            cksum_field_len_o,
   input  logic [15:0]                  cksum_val_i,
   input  logic                         cksum_ready_i,
   output logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o
);

   localparam int unsigned IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
   localparam int unsigned SUM_W = ADDR_W + 1;
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef logic [HDR_MAX_LEN-1:0][7:0] hdr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_START,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   hdr_t               work_q, work_d;
   hdr_t               out_q, out_d;
   hdr_t               ckhdr_q, ckhdr_d;
   logic [ADDR_W-1:0]  fs_q, fs_d;
   logic [ADDR_W-1:0]  fl_q, fl_d;
   logic [IDX_W-1:0]   off_q, off_d;
   logic [ADDR_W-1:0]  cfs_q, cfs_d;
   logic [ADDR_W-1:0]  cfl_q, cfl_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        val_q, val_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   // Request validation, done at full width plus one so huge inputs cannot wrap.
   logic [SUM_W-1:0]   req_end, off_end;
   logic               req_bad;
   logic [IDX_W-1:0]   req_off, req_off1;

   assign req_end  = SUM_W'(field_start_i) + SUM_W'(field_len_i);
   assign off_end  = SUM_W'(cksum_off_i) + SUM_W'(2);
   assign req_bad  = (req_end > SUM_W'(HDR_MAX_LEN)) || (off_end > SUM_W'(HDR_MAX_LEN)) ||
                     (field_len_i == '0);
   assign req_off  = cksum_off_i[IDX_W-1:0];
   assign req_off1 = req_off + IDX_W'(1);

   // Odd-length padding byte sits just past the region; it may fall off the buffer end.
   logic [ADDR_W-1:0]  pad_pos, fl_even;
   logic               pad_in;
   logic [IDX_W-1:0]   pad_idx, off1_q;
   logic [CNT_W-1:0]   cnt_inc;

   assign pad_pos = fs_q + fl_q;
   assign pad_in  = fl_q[0] && (pad_pos < ADDR_W'(HDR_MAX_LEN));
   assign pad_idx = pad_pos[IDX_W-1:0];
   assign fl_even = fl_q + ADDR_W'(fl_q[0]);
   assign off1_q  = off_q + IDX_W'(1);
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      out_d   = out_q;
      ckhdr_d = ckhdr_q;
      fs_d    = fs_q;
      fl_d    = fl_q;
      off_d   = off_q;
      cfs_d   = cfs_q;
      cfl_d   = cfl_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (req_bad) begin
                  err_d = 1'b1;
               end else begin
                  work_d           = pkt_hdr_i;
                  work_d[req_off]  = 8'h00;
                  work_d[req_off1] = 8'h00;
                  fs_d             = field_start_i;
                  fl_d             = field_len_i;
                  off_d            = req_off;
                  state_d          = S_PREP;
               end
            end
         end
         S_PREP: begin
            ckhdr_d = work_q;
            if (pad_in) begin
               ckhdr_d[pad_idx] = 8'h00;
            end
            cfs_d   = fs_q;
            cfl_d   = fl_even;
            start_d = 1'b1;
            state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // First WAIT cycle (cnt_q == 0) may still see the previous run's ready.
            if ((cnt_q != '0) && cksum_ready_i) begin
               val_d   = cksum_val_i;
               state_d = S_WRITE;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WRITE: begin
            work_d[off_q]  = val_q[15:8];
            work_d[off1_q] = val_q[7:0];
            out_d          = work_d;
            done_d         = 1'b1;
            state_d        = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         out_q   <= '0;
         ckhdr_q <= '0;
         fs_q    <= '0;
         fl_q    <= '0;
         off_q   <= '0;
         cfs_q   <= '0;
         cfl_q   <= '0;
         cnt_q   <= '0;
         val_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         out_q   <= out_d;
         ckhdr_q <= ckhdr_d;
         fs_q    <= fs_d;
         fl_q    <= fl_d;
         off_q   <= off_d;
         cfs_q   <= cfs_d;
         cfl_q   <= cfl_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cksum_start_o       = start_q;
   assign cksum_hdr_o         = ckhdr_q;
   assign cksum_field_start_o = cfs_q;
   assign cksum_field_len_o   = cfl_q;
   assign pkt_hdr_o           = out_q;
   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign err_o               = err_q;

endmodule

// File: tb/tb_cksum_update.sv
// Randomized self-checking bench for cksum_update with a behavioural checksum-unit stub
// and a byte-level internet-checksum reference model.
module tb_cksum_update;

   localparam int unsigned HDR = 64;
   localparam int unsigned AW  = 32;

   typedef logic [HDR-1:0][7:0] hdr_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           start_i;
   hdr_t           pkt_hdr_i;
   logic [AW-1:0]  field_start_i, field_len_i, cksum_off_i;
   logic           cksum_start_o;
   hdr_t           cksum_hdr_o;
   logic [AW-1:0]  cksum_field_start_o, cksum_field_len_o;
   logic [15:0]    cksum_val_i;
   logic           cksum_ready_i;
   hdr_t           pkt_hdr_o;
   logic           busy_o, done_o, err_o;

   int   checks   = 0;
   int   failures = 0;
   hdr_t last_out;

   // Stub configuration, set by the stimulus before each request
   int   stub_lat   = 0;
   bit   stub_late  = 0;
   bit   stub_never = 0;
   int   stub_dly;
   bit   stub_pend, stub_late_q;
   logic [15:0] stub_next;

   always #5 clk = ~clk;

   cksum_update dut (
      .clk                 (clk),
      .rst                 (rst),
      .start_i             (start_i),
      .pkt_hdr_i           (pkt_hdr_i),
      .field_start_i       (field_start_i),
      .field_len_i         (field_len_i),
      .cksum_off_i         (cksum_off_i),
      .cksum_start_o       (cksum_start_o),
      .cksum_hdr_o         (cksum_hdr_o),
      .cksum_field_start_o (cksum_field_start_o),
      .cksum_field_len_o   (cksum_field_len_o),
      .cksum_val_i         (cksum_val_i),
      .cksum_ready_i       (cksum_ready_i),
      .pkt_hdr_o           (pkt_hdr_o),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .err_o               (err_o)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Checksum unit as seen by the DUT: sums big-endian words over the even-length region.
   function automatic logic [15:0] stub_sum(input hdr_t h, input logic [AW-1:0] fs,
                                            input logic [AW-1:0] len);
      logic [31:0] s = 0;
      logic [7:0]  hi, lo;
      for (int i = 0; i < int'(len); i += 2) begin
         hi = (int'(fs) + i < HDR)     ? h[int'(fs) + i]     : 8'h00;
         lo = (int'(fs) + i + 1 < HDR) ? h[int'(fs) + i + 1] : 8'h00;
         s += {16'h0, hi, lo};
      end
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      return ~s[15:0];
   endfunction

   // Reference: checksum of the original header with its checksum field treated as zero.
   function automatic logic [15:0] ref_cksum(input hdr_t h, input int fs, input int fl,
                                             input int off);
      hdr_t        b = h;
      int unsigned s = 0;
      b[off]     = 8'h00;
      b[off + 1] = 8'h00;
      for (int i = 0; i < fl; i += 2)
         s += 256 * b[fs + i] + ((i + 1 < fl) ? int'(b[fs + i + 1]) : 0);
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      return ~(16'(s));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         stub_pend     <= 1'b0;
         stub_late_q   <= 1'b0;
         cksum_ready_i <= 1'b1;
         cksum_val_i   <= 16'hDEAD;
      end else if (cksum_start_o) begin
         stub_pend   <= !stub_never;
         stub_dly    <= stub_lat;
         stub_late_q <= stub_late;
         stub_next   <= stub_sum(cksum_hdr_o, cksum_field_start_o, cksum_field_len_o);
         if (!stub_late) cksum_ready_i <= 1'b0;
      end else if (stub_late_q) begin
         cksum_ready_i <= 1'b0;
         stub_late_q   <= 1'b0;
      end else if (stub_pend) begin
         if (stub_dly == 0) begin
            cksum_ready_i <= 1'b1;
            cksum_val_i   <= stub_next;
            stub_pend     <= 1'b0;
         end else begin
            stub_dly <= stub_dly - 1;
         end
      end
   end

   task automatic run_req(input hdr_t h, input int fs, input int fl, input int off,
                          input int lat, input bit late, input bit never);
      bit   rej, fin, got_done, got_err, extra;
      int   c, start_cyc, end_cyc, n_start;
      hdr_t exp_ck, exp_out;
      logic [15:0] v;
      rej = (fs + fl > HDR) || (off + 2 > HDR) || (fl == 0);
      stub_lat = lat; stub_late = late; stub_never = never;
      @(negedge clk);
      pkt_hdr_i = h; field_start_i = AW'(fs); field_len_i = AW'(fl);
      cksum_off_i = AW'(off); start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      if (rej) begin
         check("rej_err", err_o, 1'b1);
         check("rej_busy", busy_o, 1'b0);
         extra = 0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            extra |= busy_o | cksum_start_o | done_o | err_o;
         end
         check("rej_quiet", extra, 1'b0);
         check("rej_hdr", pkt_hdr_o, last_out);
         return;
      end
      check("acc_busy", busy_o, 1'b1);
      exp_ck = h; exp_ck[off] = 8'h00; exp_ck[off + 1] = 8'h00;
      if ((fl % 2 == 1) && (fs + fl < HDR)) exp_ck[fs + fl] = 8'h00;
      v = ref_cksum(h, fs, fl, off);
      exp_out = h; exp_out[off] = v[15:8]; exp_out[off + 1] = v[7:0];
      c = 1; fin = 0; got_done = 0; got_err = 0; n_start = 0; start_cyc = 0; end_cyc = 0;
      while (!fin && c <= 400) begin
         if (cksum_start_o) begin
            n_start++; start_cyc = c;
            check("ck_hdr", cksum_hdr_o, exp_ck);
            check("ck_fs", cksum_field_start_o, AW'(fs));
            check("ck_fl", cksum_field_len_o, AW'(fl + fl % 2));
         end
         if (done_o) begin got_done = 1; end_cyc = c; fin = 1; end
         else if (err_o) begin got_err = 1; end_cyc = c; fin = 1; end
         if (!fin) begin @(negedge clk); c++; end
      end
      check("n_start", n_start, 1);
      check("start_cyc", start_cyc, 2);
      if (never) begin
         check("to_err", got_err, 1'b1);
         check("to_lat", end_cyc - start_cyc, 256);
         check("to_hdr", pkt_hdr_o, last_out);
      end else begin
         check("done", got_done, 1'b1);
         check("no_err", got_err, 1'b0);
         check("done_lat", end_cyc, 6 + lat + int'(late));
         check("out_hdr", pkt_hdr_o, exp_out);
         last_out = exp_out;
      end
      @(negedge clk);
      check("pulse_end", {done_o, err_o, busy_o}, 3'b000);
   endtask

   initial begin
      hdr_t        h;
      logic [159:0] ip;
      int          c;
      bit          extra;
      rst = 1'b1; start_i = 1'b0; pkt_hdr_i = '0;
      field_start_i = '0; field_len_i = '0; cksum_off_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hdr", pkt_hdr_o, '0);
      check("rst_ck", cksum_hdr_o, '0);
      check("rst_fld", {cksum_field_start_o, cksum_field_len_o}, '0);
      check("rst_ctl", {cksum_start_o, busy_o, done_o, err_o}, 4'b0000);
      last_out = '0;
      rst = 1'b0;

      // IPv4 header, stale ready kept high through the first WAIT cycle
      ip = 160'h4500_0073_0000_4000_4011_AABB_C0A8_0001_C0A8_00C7;
      h = '0;
      for (int i = 0; i < 20; i++) h[i] = ip[159 - 8 * i -: 8];
      run_req(h, 0, 20, 10, 1, 1'b1, 1'b0);
      check("ipv4_cks", {pkt_hdr_o[10], pkt_hdr_o[11]}, 16'hB861);

      // Odd-length region
      h = '0; h[0] = 8'h12; h[1] = 8'h34; h[2] = 8'h56; h[3] = 8'hFF;
      run_req(h, 0, 3, 8, 0, 1'b0, 1'b0);
      check("odd_cks", {pkt_hdr_o[8], pkt_hdr_o[9]}, 16'h97CB);
      check("odd_b3", pkt_hdr_o[3], 8'hFF);

      // Out-of-range region, then timeout, then a normal run
      run_req(h, 60, 8, 0, 0, 1'b0, 1'b0);
      run_req(h, 0, 3, 62, 0, 1'b0, 1'b1);
      run_req(h, 0, 4, 62, 2, 1'b0, 1'b0);

      // Reset during WAIT
      stub_never = 1'b1;
      @(negedge clk);
      pkt_hdr_i = h; field_start_i = 0; field_len_i = 4; cksum_off_i = 20; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (c = 1; c < 4; c++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ctl", {cksum_start_o, busy_o, done_o, err_o}, 4'b0000);
      check("mid_rst_hdr", pkt_hdr_o, '0);
      check("mid_rst_ck", cksum_hdr_o, '0);
      rst = 1'b0;
      extra = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         extra |= done_o | err_o | busy_o;
      end
      check("mid_rst_quiet", extra, 1'b0);
      last_out = '0;
      run_req(h, 1, 5, 30, 1, 1'b1, 1'b0);

      // Random requests, mix of valid and rejected
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < HDR; i++) h[i] = 8'($urandom);
         run_req(h, int'($urandom_range(0, 40)), int'($urandom_range(0, 30)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cksum_update.md
Name: cksum_update

Overview:
- Checksum-rewrite stage sitting directly upstream and downstream of the checksum unit.
- Latches a modified packet header and zeroes its 16-bit checksum field.
- Drives the checksum unit's start/header/field inputs, waits for its ready, then writes the returned value big-endian back into the header.
- Presents the updated header to the deparser with a one-cycle done pulse.

Parameters:
- HDR_MAX_LEN, 64, header buffer length in bytes.
- ADDR_W, 32, width of address/length fields (matches checksum unit address bus).
- TIMEOUT, 255, max cycles to wait for checksum ready before flagging error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  request pulse; sampled only in IDLE
- pkt_hdr_i  in  8 x HDR_MAX_LEN  header bytes, sampled on accepted start
- field_start_i  in  ADDR_W  first byte of checksummed region
- field_len_i  in  ADDR_W  region length in bytes
- cksum_off_i  in  ADDR_W  byte offset of 16-bit checksum field (MSB at offset)
- cksum_start_o  out  1  one-cycle start to checksum unit
- cksum_hdr_o  out  8 x HDR_MAX_LEN  header copy fed to checksum unit
- cksum_field_start_o  out  ADDR_W  region start to checksum unit
- cksum_field_len_o  out  ADDR_W  region length to checksum unit (rounded up to even)
- cksum_val_i  in  16  checksum result
- cksum_ready_i  in  1  checksum unit ready (level; stays high until next start)
- pkt_hdr_o  out  8 x HDR_MAX_LEN  updated header, valid from done until next accepted start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, header written
- err_o  out  1  one-cycle pulse, request rejected or timed out

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all outputs 0, header buffers all-zero, state IDLE, timeout counter 0. Reset mid-operation aborts immediately: no done/err pulse, cksum_start_o low next cycle.
- IDLE, start_i=1: run checks on the inputs.
  - Reject if field_start_i + field_len_i > HDR_MAX_LEN, cksum_off_i + 2 > HDR_MAX_LEN, or field_len_i == 0.
  - On reject: err_o pulses next cycle, buffers unchanged, stay IDLE.
  - Otherwise: latch pkt_hdr_i into the working buffer with bytes cksum_off, cksum_off+1 forced 0; latch offsets; go to PREP.
- PREP (1 cycle): build the checksum copy.
  - cksum_hdr_o = working buffer.
  - If field_len is odd, byte at field_start+field_len is forced 0 in cksum_hdr_o only, when that byte lies inside the buffer.
  - cksum_field_len_o = field_len rounded up to even.
  - Go to START.
- START (1 cycle): cksum_start_o=1; timeout counter cleared; go to WAIT. cksum_hdr_o and field outputs stay stable from PREP until leaving WAIT.
- WAIT: cksum_ready_i is ignored in the first WAIT cycle, because the stale ready from the previous run is cleared on the start edge.
  - From the 2nd cycle on, ready=1: capture cksum_val_i, go to WRITE.
  - Counter reaches TIMEOUT: err_o pulse, go to IDLE, pkt_hdr_o unchanged.
- WRITE (1 cycle): working[cksum_off] = val[15:8], working[cksum_off+1] = val[7:0]; pkt_hdr_o <= updated buffer; go to DONE.
- DONE (1 cycle): done_o=1; go to IDLE.
- start_i outside IDLE is ignored (no queueing).
- Latency: start accept to done_o = 4 cycles + checksum-unit cycles.
- Simultaneous ready and timeout in the same cycle: ready wins.
- Checksum field overlapping the region is expected (IPv4); it is zeroed before summing.

Test Plan:
- IPv4 header 45 00 00 73 00 00 40 00 40 11 AA BB C0 A8 00 01 C0 A8 00 C7, field_start=0, len=20, off=10 -> cksum_hdr_o bytes 10..11 = 00 00; pkt_hdr_o bytes 10..11 = B8 61; done_o one pulse; err_o never.
- Odd region start=0, len=3, bytes 12 34 56 FF, off=8 -> cksum_field_len_o=4; byte 3 sent as 00; result ~(0x1234+0x5600)=0x97CB written at bytes 8..9; pkt_hdr_o byte 3 stays FF.
- field_start=60, len=8 (HDR_MAX_LEN=64) -> err_o pulse 1 cycle after start; no cksum_start_o; busy_o stays 0.
- Stub holds cksum_ready_i=1 continuously from a previous run -> block still waits ≥1 WAIT cycle after start; value captured only once the stub's ready has dropped low and then risen again.
- Stub never raises ready, TIMEOUT=255 -> err_o exactly 256 cycles after cksum_start_o; returns to IDLE; next valid request completes normally.
- rst asserted during WAIT -> next cycle: all outputs 0, IDLE; no done/err; subsequent start_i accepted.
